// File: rtl/farrow_pkg.sv
// Shared definitions for the polynomial-evaluator share scheduler.
//  - word_t  : default sample/coefficient word
//  - state_t : scheduler sequencing state (flush after reset, then run)
//  - id_w    : width of a requester ID for a given requester count
//  - rr_pick : round-robin select over a request vector, starting after ptr
package farrow_pkg;

  localparam int PKG_BITS = 16;
  // rr_pick works on a fixed-width vector; requester counts up to this value.
  localparam int RR_MAX   = 32;

  typedef logic [PKG_BITS-1:0] word_t;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  function automatic int id_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // First set bit of vec[m-1:0] searching from ptr+1 upward, wrapping modulo m.
  // ptr < m is assumed, so ptr+k (k<=m) needs at most one wrap subtraction.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] vec,
                                       input logic [4:0]        ptr,
                                       input int                m);
    rr_pick_t   r;
    logic [5:0] s;
    r = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= m) begin
        s = 6'(ptr) + 6'(k);
        if (s >= 6'(m)) s = s - 6'(m);
        if (!r.found && vec[s[4:0]]) begin
          r.found = 1'b1;
          r.idx   = s[4:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO holding requester IDs of issues still in the evaluator.
// Depth need not be a power of two. Push and pop in the same cycle are
// legal at any fill level, including full (the head is read before the
// slot is overwritten). Push while full without pop and pop while empty
// are ignored.
// Ports:
//  clk, rstn  clock, synchronous active-low reset (empties the FIFO)
//  push, din  write din at tail
//  pop        drop head
//  full/empty occupancy flags
//  head       oldest entry
module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_do_pop;
  logic          w_do_push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CW'(DEPTH));
  assign head      = r_mem[r_rd];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= nxt(r_wr);
      if (w_do_pop)  r_rd <= nxt(r_rd);
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/poly_share_sched.sv
// Shares one fixed-latency polynomial evaluator between M requesters.
// Round-robin grant (combinational ack), registered issue of the winner's
// coef/x, requester ID tagged in a FIFO, result returned with its ID.
// After reset, a LATENCY-cycle flush discards results still in the
// evaluator from before the reset.
// Handshake: req is held by a requester until ack; ack is one-hot and
// accepts the request in that same cycle. Evaluator and response sides
// are strobes with no backpressure.
// Ports:
//  clk, rstn                      clock, synchronous active-low reset
//  req/req_coef/req_x             per-requester request and operands
//  ack                            one-hot grant
//  poly_in_valid/coef/xin         issue to evaluator
//  poly_out_valid/poly_yout       evaluator result
//  resp_valid/resp_id/resp_y      tagged result
//  busy                           flushing or results outstanding
//  err_underflow                  sticky: result with no outstanding issue
module poly_share_sched
  import farrow_pkg::*;
#(
  parameter int BITS    = PKG_BITS,
  parameter int N       = 3,
  parameter int M       = 4,
  parameter int LATENCY = 8,
  parameter int MAX_OUT = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [M-1:0]                   req,
  input  logic [M-1:0][N-1:0][BITS-1:0]  req_coef,
  input  logic [M-1:0][BITS-1:0]         req_x,
  output logic [M-1:0]                   ack,
  output logic                           poly_in_valid,
  output logic [N-1:0][BITS-1:0]         poly_coef,
  output logic [BITS-1:0]                poly_xin,
  input  logic                           poly_out_valid,
  input  logic [BITS-1:0]                poly_yout,
  output logic                           resp_valid,
  output logic [id_w(M)-1:0]             resp_id,
  output logic [BITS-1:0]                resp_y,
  output logic                           busy,
  output logic                           err_underflow
);

  localparam int ID_W = id_w(M);
  localparam int CW   = $clog2(LATENCY + 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [ID_W-1:0]         r_ptr;
  logic                    r_in_valid;
  logic [N-1:0][BITS-1:0]  r_coef;
  logic [BITS-1:0]         r_x;
  logic                    r_resp_valid;
  logic [ID_W-1:0]         r_resp_id;
  logic [BITS-1:0]         r_resp_y;
  logic                    r_err;

  logic                    w_flush;
  logic                    w_pop;
  logic                    w_underflow;
  logic                    w_room;
  logic [M-1:0]            w_elig;
  logic [RR_MAX-1:0]       w_elig_ext;
  logic [4:0]              w_ptr_ext;
  rr_pick_t                w_pick;
  logic [M-1:0]            w_ack;
  logic                    w_grant;
  logic [ID_W-1:0]         w_win;
  logic                    w_full;
  logic                    w_empty;
  logic [ID_W-1:0]         w_head;

  // Flush sequencing: the counter is loaded with LATENCY on reset and the
  // FSM leaves FLUSH once the counter has run down to zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_FLUSH: begin
        if (r_cnt != '0)       w_cnt_nxt   = r_cnt - CW'(1);
        if (r_cnt <= CW'(1))   w_state_nxt = ST_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_FLUSH;
      r_cnt   <= CW'(LATENCY);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_flush = (r_state == ST_FLUSH);

  // A result only pops when a tag is present; a result with no tag is the
  // underflow error and leaves the FIFO untouched.
  assign w_pop       = poly_out_valid && !w_flush && !w_empty;
  assign w_underflow = poly_out_valid && !w_flush &&  w_empty;

  // FIFO occupancy is the outstanding-issue count, so "full" means
  // MAX_OUT in flight; a pop in the same cycle frees the slot.
  assign w_room = !w_full || w_pop;

  always_comb begin
    w_elig                = req & {M{!w_flush && w_room}};
    w_elig_ext            = '0;
    w_elig_ext[M-1:0]     = w_elig;
    w_ptr_ext             = '0;
    w_ptr_ext[ID_W-1:0]   = r_ptr;
    w_pick                = rr_pick(w_elig_ext, w_ptr_ext, M);
    w_grant               = w_pick.found;
    w_win                 = w_pick.idx[ID_W-1:0];
    w_ack                 = '0;
    for (int i = 0; i < M; i++) begin
      w_ack[i] = w_pick.found && (w_pick.idx == 5'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr        <= ID_W'(M - 1);
      r_in_valid   <= 1'b0;
      r_coef       <= '0;
      r_x          <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_y     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_in_valid <= w_grant;
      if (w_grant) begin
        r_ptr  <= w_win;
        r_coef <= req_coef[w_win];
        r_x    <= req_x[w_win];
      end
      r_resp_valid <= w_pop;
      if (w_pop) begin
        r_resp_id <= w_head;
        r_resp_y  <= poly_yout;
      end
      if (w_underflow) r_err <= 1'b1;
    end
  end

  tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (ID_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_grant),
    .din   (w_win),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign ack           = w_ack;
  assign poly_in_valid = r_in_valid;
  assign poly_coef     = r_coef;
  assign poly_xin      = r_x;
  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_resp_id;
  assign resp_y        = r_resp_y;
  assign busy          = w_flush || !w_empty;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_poly_share_sched.sv
// Directed bench for poly_share_sched. Two instances: u_a with default
// MAX_OUT=8, u_b with MAX_OUT=4 for the credit-limit scenarios. Each has
// its own evaluator model: LATENCY-deep delay line, y = x + coef[0].
module tb_poly_share_sched;

  localparam int BITS = 16;
  localparam int N    = 3;
  localparam int M    = 4;
  localparam int LAT  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // ---------------- DUT signals ----------------
  logic [M-1:0]                  req_a, req_b;
  logic [M-1:0][N-1:0][BITS-1:0] req_coef;
  logic [M-1:0][BITS-1:0]        req_x;
  logic [M-1:0]                  ack_a, ack_b;
  logic                          iv_a, iv_b;
  logic [N-1:0][BITS-1:0]        pc_a, pc_b;
  logic [BITS-1:0]               px_a, px_b;
  logic                          ov_a, ov_b;
  logic [BITS-1:0]               py_a, py_b;
  logic                          rv_a, rv_b;
  logic [1:0]                    rid_a, rid_b;
  logic [BITS-1:0]               ry_a, ry_b;
  logic                          busy_a, busy_b, err_a, err_b;
  logic                          force_ov;

  poly_share_sched #(.BITS(BITS), .N(N), .M(M), .LATENCY(LAT), .MAX_OUT(8)) u_a (
    .clk(clk), .rstn(rstn), .req(req_a), .req_coef(req_coef), .req_x(req_x),
    .ack(ack_a), .poly_in_valid(iv_a), .poly_coef(pc_a), .poly_xin(px_a),
    .poly_out_valid(ov_a), .poly_yout(py_a), .resp_valid(rv_a), .resp_id(rid_a),
    .resp_y(ry_a), .busy(busy_a), .err_underflow(err_a));

  poly_share_sched #(.BITS(BITS), .N(N), .M(M), .LATENCY(LAT), .MAX_OUT(4)) u_b (
    .clk(clk), .rstn(rstn), .req(req_b), .req_coef(req_coef), .req_x(req_x),
    .ack(ack_b), .poly_in_valid(iv_b), .poly_coef(pc_b), .poly_xin(px_b),
    .poly_out_valid(ov_b), .poly_yout(py_b), .resp_valid(rv_b), .resp_id(rid_b),
    .resp_y(ry_b), .busy(busy_b), .err_underflow(err_b));

  // ---------------- evaluator models (not reset by rstn) ----------------
  logic [LAT-1:0]  dv_a = '0, dv_b = '0;
  logic [BITS-1:0] dy_a [LAT];
  logic [BITS-1:0] dy_b [LAT];

  always @(posedge clk) begin
    dv_a     <= {dv_a[LAT-2:0], (iv_a === 1'b1)};
    dv_b     <= {dv_b[LAT-2:0], (iv_b === 1'b1)};
    dy_a[0]  <= px_a + pc_a[0];
    dy_b[0]  <= px_b + pc_b[0];
    for (int k = 1; k < LAT; k++) begin
      dy_a[k] <= dy_a[k-1];
      dy_b[k] <= dy_b[k-1];
    end
  end

  assign ov_a = dv_a[LAT-1] | force_ov;
  assign py_a = dy_a[LAT-1];
  assign ov_b = dv_b[LAT-1];
  assign py_b = dy_b[LAT-1];

  // ---------------- scoreboard ----------------
  int              n_vec = 0;
  int              n_err = 0;
  logic [BITS-1:0] exp_q [$];
  logic [BITS-1:0] y_exp [M];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare in %s", tag);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    req_a    = '0;
    req_b    = '0;
    force_ov = 1'b0;
    step();
    step();
    #1;
    chk("rst_ack_a",   32'(ack_a), 0);
    chk("rst_iv_a",    32'(iv_a),  0);
    chk("rst_coef0_a", 32'(pc_a[0]), 0);
    chk("rst_coef2_a", 32'(pc_a[2]), 0);
    chk("rst_xin_a",   32'(px_a),  0);
    chk("rst_rv_a",    32'(rv_a),  0);
    chk("rst_rid_a",   32'(rid_a), 0);
    chk("rst_ry_a",    32'(ry_a),  0);
    chk("rst_err_a",   32'(err_a), 0);
    chk("rst_busy_a",  32'(busy_a), 1);
    chk("rst_ack_b",   32'(ack_b), 0);
    chk("rst_err_b",   32'(err_b), 0);
    rstn = 1'b1;
    repeat (10) step();
    #1;
    chk("post_flush_busy_a", 32'(busy_a), 0);
  endtask

  // u_b with req_b=pat held 23 cycles. MAX_OUT=4, result pops 9 cycles
  // after ack, so grants come in bursts of 4 every 9 cycles and the
  // burst at cycle 9 (and 18) coincides with pops at a full FIFO.
  task automatic run_b(input logic [M-1:0] pat, input bit multi);
    logic [M-1:0] e_ack;
    int           id;
    for (int c = 0; c < 23; c++) begin
      step();
      if (c == 0) req_b = pat;
      #1;
      if ((c % 9) < 4) e_ack = multi ? M'(1 << (c % 9)) : 4'b0001;
      else             e_ack = '0;
      chk(multi ? "sim_ack" : "credit_ack", 32'(ack_b), 32'(e_ack));
      if (c >= 10 && ((c - 10) % 9) < 4) begin
        id = multi ? ((c - 10) % 9) : 0;
        chk("b_rv",  32'(rv_b),  1);
        chk("b_rid", 32'(rid_b), 32'(id));
        chk("b_ry",  32'(ry_b),  32'(y_exp[id]));
      end else begin
        chk("b_rv_idle", 32'(rv_b), 0);
      end
    end
    req_b = '0;
    repeat (15) step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn     = 1'b0;
    req_a    = '0;
    req_b    = '0;
    force_ov = 1'b0;
    req_x    = '0;
    req_coef = '0;
    req_x[0] = 16'h1000; req_coef[0][0] = 16'h0005;
    req_x[1] = 16'h2000; req_coef[1][0] = 16'h0007;
    req_x[2] = 16'h0100; req_coef[2][0] = 16'h0001;
    req_x[3] = 16'h3000; req_coef[3][0] = 16'h000b;
    for (int i = 0; i < M; i++) begin
      req_coef[i][1] = 16'h1111 * 16'(i + 1);
      req_coef[i][2] = 16'h2222 * 16'(i + 1);
    end
    y_exp[0] = 16'h1005;
    y_exp[1] = 16'h2007;
    y_exp[2] = 16'h0101;
    y_exp[3] = 16'h300b;

    do_reset();

    // Single request from requester 2
    for (int c = 0; c <= 10; c++) begin
      step();
      if (c == 0) req_a = 4'b0100;
      if (c == 1) req_a = 4'b0000;
      #1;
      if (c == 0) chk("single_ack", 32'(ack_a), 32'h4);
      if (c == 1) begin
        chk("single_iv",    32'(iv_a),    1);
        chk("single_xin",   32'(px_a),    32'h0100);
        chk("single_coef0", 32'(pc_a[0]), 32'h0001);
        chk("single_coef1", 32'(pc_a[1]), 32'h3333);
        chk("single_ack0",  32'(ack_a),   0);
      end
      if (c == 2) begin
        chk("single_iv_low",   32'(iv_a), 0);
        chk("single_xin_hold", 32'(px_a), 32'h0100);
      end
      if (c == 9)  chk("single_rv_early", 32'(rv_a), 0);
      if (c == 10) begin
        chk("single_rv",  32'(rv_a),  1);
        chk("single_rid", 32'(rid_a), 2);
        chk("single_ry",  32'(ry_a),  32'h0101);
      end
    end

    // Round-robin with all requesters held for 8 grants
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(y_exp[i % 4]);
    for (int c = 0; c <= 17; c++) begin
      step();
      if (c == 0) req_a = 4'b1111;
      if (c == 8) req_a = 4'b0000;
      #1;
      if (c < 8) chk("rr_ack", 32'(ack_a), 32'(1 << (c % 4)));
      if (c >= 1 && c <= 8) begin
        chk("rr_iv",  32'(iv_a), 1);
        chk("rr_xin", 32'(px_a), 32'(req_x[(c - 1) % 4]));
      end
      if (c == 9) chk("rr_rv_early", 32'(rv_a), 0);
      if (c >= 10) begin
        chk("rr_rv",  32'(rv_a),  1);
        chk("rr_rid", 32'(rid_a), 32'((c - 10) % 4));
        if (exp_q.size() > 0) chk("rr_ry", 32'(ry_a), 32'(exp_q.pop_front()));
      end
    end
    chk("rr_queue_drained", 32'(exp_q.size()), 0);

    // Credit limit, single requester, MAX_OUT=4
    do_reset();
    run_b(4'b0001, 1'b0);

    // Simultaneous grant and pop at a full FIFO, all requesters
    do_reset();
    run_b(4'b1111, 1'b1);

    // Reset mid-flight: 5 issues, one reset cycle, stale results drained
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      step();
      if (c == 0) req_a = 4'b1111;
      if (c == 5) req_a = 4'b0000;
      #1;
      if (c < 5) chk("mid_ack", 32'(ack_a), 32'(1 << (c % 4)));
    end
    step();
    rstn = 1'b0;
    step();
    rstn  = 1'b1;
    req_a = 4'b1111;
    #1;
    chk("mid_iv_cleared", 32'(iv_a), 0);
    chk("mid_busy",       32'(busy_a), 1);
    for (int c = 7; c <= 14; c++) begin
      if (c > 7) begin
        step();
        #1;
      end
      chk("mid_flush_ack", 32'(ack_a), 0);
      chk("mid_flush_rv",  32'(rv_a),  0);
      chk("mid_flush_err", 32'(err_a), 0);
    end
    step();
    #1;
    chk("mid_resume_ack", 32'(ack_a), 32'h1);
    step();
    req_a = '0;
    repeat (12) step();
    #1;
    chk("mid_err_final", 32'(err_a), 0);
    chk("mid_busy_idle", 32'(busy_a), 0);

    // Underflow: result strobe with no outstanding issue
    step();
    force_ov = 1'b1;
    #1;
    chk("uf_err_before", 32'(err_a), 0);
    step();
    force_ov = 1'b0;
    #1;
    chk("uf_err_set", 32'(err_a), 1);
    chk("uf_rv",      32'(rv_a),  0);
    repeat (3) step();
    #1;
    chk("uf_err_sticky", 32'(err_a), 1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
